// File: rtl/wave_pattern_sequencer.sv
// Wave pattern sequencer: steps a square-wave generator through a small table
// of {on, off, repeat} entries. Each entry plays (rep+1) periods of
// (m+n)*UNIT clock cycles. The sequence ends on an all-zero entry or after the
// last table slot, and can optionally loop back to entry 0.
module wave_pattern_sequencer #(
    parameter int DEPTH = 4,
    parameter int UNIT  = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [3:0]    cfg_m,
    input  logic [3:0]    cfg_n,
    input  logic [3:0]    cfg_rep,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic [3:0]    m_out,
    output logic [3:0]    n_out,
    output logic          gen_reset,
    output logic          busy,
    output logic [AW-1:0] seg_idx,
    output logic          done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Pattern table; deliberately not cleared by reset so a configured
    // pattern survives a reset.
    logic [3:0] tbl_m   [DEPTH];
    logic [3:0] tbl_n   [DEPTH];
    logic [3:0] tbl_rep [DEPTH];

    state_t        state_reg, state_next;
    logic [3:0]    m_reg, m_next;
    logic [3:0]    n_reg, n_next;
    logic [3:0]    rep_reg, rep_next;       // repeat limit of the playing entry
    logic [3:0]    rcnt_reg, rcnt_next;     // periods already played minus one
    logic [11:0]   cyc_reg, cyc_next;       // cycle within the current period
    logic [AW-1:0] seg_reg, seg_next;
    logic          gen_reset_reg, gen_reset_next;
    logic          done_reg, done_next;

    logic [DEPTH-1:0] is_end;
    logic [AW-1:0]    seg_plus;
    logic [AW-1:0]    load_idx;
    logic [31:0]      period_len;
    logic             last_cycle;
    logic             wrap_or_end;

    // Table write port; a write on an advance edge lands after the load reads
    // the old content.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_m[cfg_addr]   <= cfg_m;
            tbl_n[cfg_addr]   <= cfg_n;
            tbl_rep[cfg_addr] <= cfg_rep;
        end
    end

    // An entry with m+n==0 marks the end of the sequence.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_end_mark
            assign is_end[gi] = (tbl_m[gi] == 4'd0) && (tbl_n[gi] == 4'd0);
        end
    endgenerate

    // Period length computed wide so (15+15)*UNIT never truncates.
    assign period_len  = ({28'd0, m_reg} + {28'd0, n_reg}) * 32'(UNIT);
    assign last_cycle  = ({20'd0, cyc_reg} == (period_len - 32'd1));
    assign seg_plus    = seg_reg + AW'(1);
    assign wrap_or_end = (seg_reg == AW'(DEPTH - 1)) || is_end[seg_plus];
    assign load_idx    = wrap_or_end ? '0 : seg_plus;

    // State and output registers; reset returns to an idle, generator-held state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            m_reg         <= 4'd0;
            n_reg         <= 4'd0;
            rep_reg       <= 4'd0;
            rcnt_reg      <= 4'd0;
            cyc_reg       <= 12'd0;
            seg_reg       <= '0;
            gen_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            m_reg         <= m_next;
            n_reg         <= n_next;
            rep_reg       <= rep_next;
            rcnt_reg      <= rcnt_next;
            cyc_reg       <= cyc_next;
            seg_reg       <= seg_next;
            gen_reset_reg <= gen_reset_next;
            done_reg      <= done_next;
        end
    end

    // Next-state logic: start/stop handling, period counting and entry advance.
    always_comb begin
        state_next     = state_reg;
        m_next         = m_reg;
        n_next         = n_reg;
        rep_next       = rep_reg;
        rcnt_next      = rcnt_reg;
        cyc_next       = cyc_reg;
        seg_next       = seg_reg;
        gen_reset_next = gen_reset_reg;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                gen_reset_next = 1'b1;
                if (start) begin
                    if (is_end[0]) begin
                        done_next = 1'b1;
                    end else begin
                        state_next     = RUN;
                        m_next         = tbl_m[0];
                        n_next         = tbl_n[0];
                        rep_next       = tbl_rep[0];
                        seg_next       = '0;
                        cyc_next       = 12'd0;
                        rcnt_next      = 4'd0;
                        gen_reset_next = 1'b0;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort wins over any advance on the same edge; no done.
                    state_next     = IDLE;
                    gen_reset_next = 1'b1;
                    cyc_next       = 12'd0;
                    rcnt_next      = 4'd0;
                end else if (last_cycle) begin
                    cyc_next = 12'd0;
                    if (rcnt_reg < rep_reg) begin
                        rcnt_next = rcnt_reg + 4'd1;
                    end else begin
                        rcnt_next = 4'd0;
                        if (wrap_or_end && !(loop && !is_end[0])) begin
                            state_next     = IDLE;
                            gen_reset_next = 1'b1;
                            done_next      = 1'b1;
                        end else begin
                            // Generator wraps on this same edge, so no
                            // gen_reset pulse is needed between entries.
                            m_next   = tbl_m[load_idx];
                            n_next   = tbl_n[load_idx];
                            rep_next = tbl_rep[load_idx];
                            seg_next = load_idx;
                        end
                    end
                end else begin
                    cyc_next = cyc_reg + 12'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_out     = m_reg;
    assign n_out     = n_reg;
    assign seg_idx   = seg_reg;
    assign gen_reset = gen_reset_reg;
    assign done      = done_reg;
    assign busy      = (state_reg == RUN);

endmodule

// File: tb/tb_wave_pattern_sequencer.sv
// Directed testbench for wave_pattern_sequencer (DEPTH=4, UNIT=10).
module tb_wave_pattern_sequencer;

    localparam int DEPTH = 4;
    localparam int UNIT  = 10;
    localparam int AW    = 2;

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [3:0]    cfg_m;
    logic [3:0]    cfg_n;
    logic [3:0]    cfg_rep;
    logic          start;
    logic          stop;
    logic          loop;
    logic [3:0]    m_out;
    logic [3:0]    n_out;
    logic          gen_reset;
    logic          busy;
    logic [AW-1:0] seg_idx;
    logic          done;

    int total = 0;
    int bad   = 0;

    wave_pattern_sequencer #(.DEPTH(DEPTH), .UNIT(UNIT), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_m     (cfg_m),
        .cfg_n     (cfg_n),
        .cfg_rep   (cfg_rep),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .m_out     (m_out),
        .n_out     (n_out),
        .gen_reset (gen_reset),
        .busy      (busy),
        .seg_idx   (seg_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table write in IDLE; returns on a falling edge with cfg_we low.
    task automatic write_entry(input logic [AW-1:0] a, input logic [3:0] m,
                               input logic [3:0] n, input logic [3:0] r);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_m = m; cfg_n = n; cfg_rep = r;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Start pulse; returns on the falling edge right after the start edge.
    task automatic kick(input logic with_stop);
        @(negedge clk);
        start = 1'b1; stop = with_stop;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (m_out !== 4'd0 || n_out !== 4'd0 || seg_idx !== 2'd0 || gen_reset !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: m=%0d n=%0d seg=%0d gr=%b busy=%b done=%b, want 0 0 0 1 0 0",
                     m_out, n_out, seg_idx, gen_reset, busy, done);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || gen_reset !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_release: busy=%b gr=%b, want 0 1", busy, gen_reset);
        end
        $display("test_reset finished");
    endtask

    task automatic test_single;
        int run_len = 0; int err = 0; int ended = 0;
        logic d = 1'b0; logic g = 1'b0;
        write_entry(2'd0, 4'd2, 4'd1, 4'd1);
        write_entry(2'd1, 4'd0, 4'd0, 4'd0);
        loop = 1'b0;
        kick(1'b0);
        for (int i = 0; i < 200 && ended == 0; i++) begin
            if (i > 0) @(negedge clk);
            if (busy === 1'b1) begin
                run_len++;
                if (m_out !== 4'd2 || n_out !== 4'd1 || done !== 1'b0 || gen_reset !== 1'b0) err++;
            end else begin
                ended = 1; d = done; g = gen_reset;
            end
        end
        total++;
        if (run_len != 60) begin bad++; $display("FAIL single_len: got %0d cycles, want 60", run_len); end
        total++;
        if (err != 0) begin bad++; $display("FAIL single_outputs: %0d bad cycles, want 0", err); end
        total++;
        if (d !== 1'b1 || g !== 1'b1) begin bad++; $display("FAIL single_end: done=%b gr=%b, want 1 1", d, g); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL single_done_width: done=%b, want 0", done); end
        $display("test_single finished: run_len=%0d", run_len);
    endtask

    task automatic test_chain;
        int c0 = 0; int c1 = 0; int ended = 0;
        logic [3:0] m19 = 4'hf; logic [3:0] m20 = 4'hf; logic [3:0] n20 = 4'hf;
        logic d = 1'b0;
        write_entry(2'd0, 4'd1, 4'd1, 4'd0);
        write_entry(2'd1, 4'd3, 4'd0, 4'd0);
        write_entry(2'd2, 4'd0, 4'd0, 4'd0);
        loop = 1'b0;
        kick(1'b0);
        for (int i = 0; i < 200 && ended == 0; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 19) m19 = m_out;
            if (i == 20) begin m20 = m_out; n20 = n_out; end
            if (busy !== 1'b1) begin ended = 1; d = done; end
            else if (seg_idx === 2'd0) c0++;
            else if (seg_idx === 2'd1) c1++;
        end
        total++;
        if (c0 != 20 || c1 != 30) begin bad++; $display("FAIL chain_lengths: seg0=%0d seg1=%0d, want 20 30", c0, c1); end
        total++;
        if (m19 !== 4'd1 || m20 !== 4'd3 || n20 !== 4'd0) begin
            bad++; $display("FAIL chain_switch: m19=%0d m20=%0d n20=%0d, want 1 3 0", m19, m20, n20);
        end
        total++;
        if (d !== 1'b1) begin bad++; $display("FAIL chain_done: done=%b, want 1", d); end
        $display("test_chain finished: seg0=%0d seg1=%0d", c0, c1);
    endtask

    task automatic test_loop;
        int end_idx = -1; int err = 0; int ended = 0;
        logic d = 1'b0;
        write_entry(2'd0, 4'd1, 4'd2, 4'd0);
        write_entry(2'd1, 4'd0, 4'd0, 4'd0);
        loop = 1'b1;
        kick(1'b0);
        for (int i = 0; i < 300 && ended == 0; i++) begin
            if (i > 0) @(negedge clk);
            if (busy !== 1'b1) begin
                ended = 1; end_idx = i; d = done;
            end else if (m_out !== 4'd1 || n_out !== 4'd2 || seg_idx !== 2'd0 || done !== 1'b0) begin
                err++;
            end
            if (i == 94) loop = 1'b0;
        end
        total++;
        if (end_idx != 120) begin bad++; $display("FAIL loop_end_cycle: got %0d, want 120", end_idx); end
        total++;
        if (err != 0) begin bad++; $display("FAIL loop_outputs: %0d bad cycles, want 0", err); end
        total++;
        if (d !== 1'b1) begin bad++; $display("FAIL loop_done: done=%b, want 1", d); end
        $display("test_loop finished: end_idx=%0d", end_idx);
    endtask

    task automatic test_full;
        int end_idx = -1; int ended = 0;
        logic [AW-1:0] seg_at [4];
        logic [AW-1:0] seg79 = '0;
        logic b0 = 1'b0; logic d = 1'b0;
        for (int k = 0; k < 4; k++) seg_at[k] = 2'd0;
        for (int k = 0; k < DEPTH; k++) write_entry(AW'(k), 4'd1, 4'd1, 4'd0);
        loop = 1'b0;
        kick(1'b1);
        for (int i = 0; i < 200 && ended == 0; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) b0 = busy;
            if (i == 0 || i == 20 || i == 40 || i == 60) seg_at[i / 20] = seg_idx;
            if (i == 79) seg79 = seg_idx;
            if (busy !== 1'b1) begin ended = 1; end_idx = i; d = done; end
        end
        total++;
        if (b0 !== 1'b1) begin bad++; $display("FAIL full_start_with_stop: busy=%b, want 1", b0); end
        total++;
        if (seg_at[0] !== 2'd0 || seg_at[1] !== 2'd1 || seg_at[2] !== 2'd2 || seg_at[3] !== 2'd3 || seg79 !== 2'd3) begin
            bad++;
            $display("FAIL full_seg: %0d %0d %0d %0d last=%0d, want 0 1 2 3 last=3",
                     seg_at[0], seg_at[1], seg_at[2], seg_at[3], seg79);
        end
        total++;
        if (end_idx != 80 || d !== 1'b1) begin
            bad++; $display("FAIL full_end: idx=%0d done=%b, want 80 1", end_idx, d);
        end
        $display("test_full finished: end_idx=%0d", end_idx);
    endtask

    task automatic test_empty;
        write_entry(2'd0, 4'd0, 4'd0, 4'd0);
        kick(1'b0);
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL empty_start: busy=%b done=%b, want 0 1", busy, done);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL empty_after: busy=%b done=%b, want 0 0", busy, done);
        end
        $display("test_empty finished");
    endtask

    task automatic test_stop;
        write_entry(2'd0, 4'd2, 4'd1, 4'd1);
        write_entry(2'd1, 4'd0, 4'd0, 4'd0);
        loop = 1'b0;
        kick(1'b0);
        for (int i = 1; i < 60; i++) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || gen_reset !== 1'b1 || m_out !== 4'd2 || n_out !== 4'd1) begin
            bad++;
            $display("FAIL stop_last_cycle: busy=%b done=%b gr=%b m=%0d n=%0d, want 0 0 1 2 1",
                     busy, done, gen_reset, m_out, n_out);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL stop_no_done: done=%b, want 0", done); end
        kick(1'b0);
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_pre_run: busy=%b, want 1", busy); end
        reset = 1'b1;
        #1;
        total++;
        if (m_out !== 4'd0 || n_out !== 4'd0 || seg_idx !== 2'd0 || busy !== 1'b0 ||
            gen_reset !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: m=%0d n=%0d seg=%0d busy=%b gr=%b done=%b, want 0 0 0 0 1 0",
                     m_out, n_out, seg_idx, busy, gen_reset, done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_no_resume: busy=%b done=%b, want 0 0", busy, done);
        end
        $display("test_stop finished");
    endtask

    task automatic test_back_to_back;
        logic [3:0] m20 = 4'hf; logic [3:0] n20 = 4'hf; logic [AW-1:0] s20 = '0;
        logic [3:0] m50 = 4'hf; logic [AW-1:0] s50 = '1;
        logic [3:0] m70 = 4'hf; logic [3:0] n70 = 4'hf; logic [AW-1:0] s70 = '0;
        write_entry(2'd0, 4'd1, 4'd1, 4'd0);
        write_entry(2'd1, 4'd1, 4'd2, 4'd0);
        write_entry(2'd2, 4'd0, 4'd0, 4'd0);
        loop = 1'b1;
        kick(1'b0);
        for (int i = 0; i <= 70; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 20) begin m20 = m_out; n20 = n_out; s20 = seg_idx; end
            if (i == 50) begin m50 = m_out; s50 = seg_idx; end
            if (i == 70) begin m70 = m_out; n70 = n_out; s70 = seg_idx; end
            if (i == 19) begin
                cfg_we = 1'b1; cfg_addr = 2'd1; cfg_m = 4'd4; cfg_n = 4'd4; cfg_rep = 4'd0;
            end
            if (i == 20) cfg_we = 1'b0;
            if (i == 70) begin stop = 1'b1; loop = 1'b0; end
        end
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (m20 !== 4'd1 || n20 !== 4'd2 || s20 !== 2'd1) begin
            bad++; $display("FAIL b2b_old_entry: m=%0d n=%0d seg=%0d, want 1 2 1", m20, n20, s20);
        end
        total++;
        if (m50 !== 4'd1 || s50 !== 2'd0) begin
            bad++; $display("FAIL b2b_wrap: m=%0d seg=%0d, want 1 0", m50, s50);
        end
        total++;
        if (m70 !== 4'd4 || n70 !== 4'd4 || s70 !== 2'd1) begin
            bad++; $display("FAIL b2b_new_entry: m=%0d n=%0d seg=%0d, want 4 4 1", m70, n70, s70);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: busy=%b, want 0", busy); end
        $display("test_back_to_back finished");
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_m = '0; cfg_n = '0; cfg_rep = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        test_reset();
        test_single();
        test_chain();
        test_loop();
        test_full();
        test_empty();
        test_stop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wave_pattern_sequencer.md
WAVE_PATTERN_SEQUENCER -- requirements
Module: wave_pattern_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: number of pattern table entries (power of 2, 2..16).
REQ-002 Parameter UNIT, default 10: clock cycles per m/n count, matching the square wave generator scaling.
REQ-003 Parameter AW, default $clog2(DEPTH): table address width.
REQ-004 Ports, one per line:
  clk        in   1   rising-edge clock
  reset      in   1   asynchronous, active-high reset
  cfg_we     in   1   table write strobe
  cfg_addr   in   AW  table write address
  cfg_m      in   4   on-interval for entry
  cfg_n      in   4   off-interval for entry
  cfg_rep    in   4   entry plays cfg_rep+1 periods (1..16)
  start      in   1   begin sequence at entry 0 (IDLE only)
  stop       in   1   abort sequence (RUN only)
  loop       in   1   1 = restart at entry 0 after last entry, sampled at sequence end
  m_out      out  4   on-interval to generator
  n_out      out  4   off-interval to generator
  gen_reset  out  1   synchronous reset to generator
  busy       out  1   high in RUN
  seg_idx    out  AW  index of entry currently driven
  done       out  1   one-cycle pulse at natural sequence end

Function
REQ-005 Table: DEPTH entries of {m,n,rep}; write on clk edge when cfg_we=1, in any state; table is not cleared by reset.
REQ-006 An entry with m+n==0 is an end marker; the sequence also ends after entry DEPTH-1.
REQ-007 States: IDLE, RUN only.
REQ-008 IDLE: gen_reset=1, busy=0; m_out, n_out, seg_idx hold their last values; stop ignored.
REQ-009 IDLE, start=1, entry 0 not an end marker: next edge -> RUN, m_out/n_out = entry 0, seg_idx=0, cycle counter=0, repeat counter=0, gen_reset=0.
REQ-010 IDLE, start=1, entry 0 is an end marker: stay IDLE, done=1 for one cycle.
REQ-011 RUN: cycle counter (12 bits) counts 0..P-1, where P=(m_out+n_out)*UNIT is computed at full width without truncation; the counter wraps to 0 on the edge after P-1.
REQ-012 At cycle P-1 with repeat counter < rep: increment repeat counter; m_out/n_out unchanged.
REQ-013 At cycle P-1 with repeat counter == rep: advance to entry seg_idx+1 on the same edge, updating m_out/n_out/seg_idx, repeat=0, cycle=0. The generator's counter wraps on that same edge, so the new period starts seamlessly with no gen_reset pulse.
REQ-014 Advance past DEPTH-1, or onto an end marker: if loop=1, load entry 0 instead (if entry 0 is itself an end marker, end sequence); otherwise go to IDLE with done=1 for one cycle.
REQ-015 The entry loaded at an advance is the table content before that edge; a simultaneous cfg_we to the same address takes effect only on a later load.
REQ-016 Writes to the entry currently playing do not alter m_out/n_out until that entry is reloaded.
REQ-017 stop=1 in RUN: next edge -> IDLE, gen_reset=1, done stays 0; stop has priority over a simultaneous advance.
REQ-018 start in RUN is ignored; start and stop together in IDLE behave as start alone.
REQ-019 done and gen_reset are registered outputs; no combinational path from inputs to outputs.

Reset
REQ-020 reset=1 asynchronously forces IDLE: m_out=0, n_out=0, seg_idx=0, gen_reset=1, busy=0, done=0, counters=0.
REQ-021 Reset asserted mid-RUN aborts the sequence with no done pulse; operation resumes only on a new start after release.

Verification
REQ-022 Single entry: e0={2,1,1}, e1={0,0,0}, loop=0, start -> busy=1 and m_out=2/n_out=1 for 60 cycles, then done=1 for 1 cycle, busy=0, gen_reset=1.
REQ-023 Chain: e0={1,1,0}, e1={3,0,0}, e2={0,0,0}, start -> seg_idx 0 for 20 cycles, seg_idx 1 for 30 cycles, then done pulse; m_out changes exactly on the 21st-cycle edge.
REQ-024 Loop: e0={1,2,0}, e1={0,0,0}, loop=1 -> m_out=1/n_out=2 repeats, 30-cycle periods, no done; drop loop -> done at end of the current 30-cycle period.
REQ-025 Full table: DEPTH=4, all entries {1,1,0}, loop=0 -> seg_idx 0,1,2,3 at 20 cycles each, done after 80 cycles.
REQ-026 Stop at cycle P-1 of the last repeat -> IDLE next edge, done=0, m_out keeps the old value; also assert reset mid-RUN -> all outputs at reset values immediately.
REQ-027 Write e1={4,4,0} on the same edge as the e0->e1 advance -> old e1 plays; the new e1 plays on the next loop pass.
